// File: rtl/song_pkg.sv
// Shared encodings and default widths for the multi-song note reader.
package song_pkg;

   localparam int SONG_BITS_DEF = 4;
   localparam int ADDR_BITS_DEF = 5;
   localparam int NOTE_W_DEF    = 6;
   localparam int DUR_W_DEF     = 6;
   localparam int META_W_DEF    = 3;

   // An all-zero ROM word terminates a song.
   localparam int END_MARKER = 0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_DECODE,
      S_ISSUE,
      S_REST,
      S_DONE
   } state_t;

endpackage

// File: rtl/rest_timer.sv
// Counts beats during a rest; done reflects the count including a beat arriving this cycle.
module rest_timer #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] target,
   input  logic         enable,
   input  logic         beat,
   output logic         done
);

   logic [W-1:0] cnt;
   logic [W-1:0] tgt;
   logic [W-1:0] cnt_inc;

   assign cnt_inc = cnt + W'(beat & enable);
   assign done    = (cnt_inc == tgt);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
         tgt <= '0;
      end else if (load) begin
         cnt <= '0;
         tgt <= target;
      end else if (enable && beat) begin
         cnt <= cnt_inc;
      end
   end

endmodule

// File: rtl/song_reader_multi.sv
// Walks a song's words in ROM, handing notes to the player and timing rests on the beat tick.
module song_reader_multi
   import song_pkg::*;
#(
   parameter int SONG_BITS = SONG_BITS_DEF,
   parameter int ADDR_BITS = ADDR_BITS_DEF,
   parameter int NOTE_W    = NOTE_W_DEF,
   parameter int DUR_W     = DUR_W_DEF,
   parameter int META_W    = META_W_DEF
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            play,
   input  logic                            loop_en,
   input  logic [SONG_BITS-1:0]            song,
   input  logic                            beat,
   output logic [SONG_BITS+ADDR_BITS-1:0]  rom_addr,
   input  logic [NOTE_W+DUR_W+META_W:0]    rom_data,
   output logic                            new_note,
   input  logic                            note_ready,
   output logic [NOTE_W-1:0]               note,
   output logic [DUR_W-1:0]                duration,
   output logic [META_W-1:0]               metadata,
   output logic                            song_done
);

   localparam int W = 1 + NOTE_W + DUR_W + META_W;

   state_t               state_q, state_d;
   logic [ADDR_BITS-1:0] note_addr, addr_d;
   logic [SONG_BITS-1:0] song_latched, song_d;
   logic                 play_q;
   logic                 timer_load, timer_en, timer_done;
   logic                 fields_load, advance, at_end, running;

   logic                 w_rest;
   logic [NOTE_W-1:0]    w_note;
   logic [DUR_W-1:0]     w_dur;
   logic [META_W-1:0]    w_meta;

   assign {w_rest, w_note, w_dur, w_meta} = rom_data;
   assign rom_addr = {song_latched, note_addr};
   assign running  = (state_q != S_IDLE) && (state_q != S_DONE);

   rest_timer #(.W(NOTE_W)) u_rest_timer (
      .clk    (clk),
      .reset  (reset),
      .load   (timer_load),
      .target (w_note),
      .enable (timer_en),
      .beat   (beat),
      .done   (timer_done)
   );

   always_comb begin
      state_d     = state_q;
      addr_d      = note_addr;
      song_d      = song_latched;
      timer_load  = 1'b0;
      timer_en    = 1'b0;
      fields_load = 1'b0;
      advance     = 1'b0;
      at_end      = 1'b0;
      case (state_q)
         S_IDLE: if (play) begin
            song_d  = song;
            addr_d  = '0;
            state_d = S_FETCH;
         end
         S_FETCH: if (play) state_d = S_WAIT;
         // a pause while the read is in flight restarts the fetch
         S_WAIT: state_d = play ? S_DECODE : S_FETCH;
         S_DECODE: if (play) begin
            if (rom_data == W'(END_MARKER)) begin
               advance = 1'b1;
               at_end  = 1'b1;
            end else if (w_rest) begin
               timer_load = 1'b1;
               state_d    = S_REST;
            end else begin
               fields_load = 1'b1;
               state_d     = S_ISSUE;
            end
         end
         S_ISSUE: if (note_ready) advance = 1'b1;
         S_REST: if (play) begin
            timer_en = 1'b1;
            if (timer_done) advance = 1'b1;
         end
         S_DONE: if (play && !play_q) begin
            song_d  = song;
            addr_d  = '0;
            state_d = S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase

      if (advance) begin
         if (at_end || note_addr == '1) begin
            if (loop_en) begin
               addr_d  = '0;
               state_d = S_FETCH;
            end else begin
               state_d = S_DONE;
            end
         end else begin
            addr_d  = note_addr + ADDR_BITS'(1);
            state_d = S_FETCH;
         end
      end

      // a new song selection overrides any transfer or beat in the same cycle
      if (running && song != song_latched) begin
         song_d      = song;
         addr_d      = '0;
         state_d     = S_FETCH;
         timer_load  = 1'b0;
         timer_en    = 1'b0;
         fields_load = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         note_addr    <= '0;
         song_latched <= '0;
         play_q       <= 1'b0;
         new_note     <= 1'b0;
         song_done    <= 1'b0;
         note         <= '0;
         duration     <= '0;
         metadata     <= '0;
      end else begin
         state_q      <= state_d;
         note_addr    <= addr_d;
         song_latched <= song_d;
         play_q       <= play;
         new_note     <= (state_d == S_ISSUE);
         song_done    <= (state_d == S_DONE);
         if (fields_load) begin
            note     <= w_note;
            duration <= w_dur;
            metadata <= w_meta;
         end
      end
   end

endmodule
